// File: rtl/iterative_divider.sv
// Radix-2 restoring divider for MIPS-style DIV/DIVU.
// A start is accepted in IDLE or DONE. The divider iterates for WIDTH cycles
// in BUSY, then pulses o_done for one cycle. The quotient and remainder stay
// held in output registers until the next division completes.
module iterative_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_signed,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             signed_q;
    logic             dvd_sign_q;
    logic             dsr_sign_q;
    logic             dbz_q;
    logic [WIDTH-1:0] rem_q;      // partial remainder
    logic [WIDTH-1:0] quo_q;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dsr_q;      // divisor magnitude

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             div_by_zero_q;

    // Operand magnitudes at capture time
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dsr_mag;

    // One restoring step, plus the sign-corrected final values
    logic [WIDTH:0]   shifted_rem;
    logic [WIDTH:0]   trial;
    logic             step_ok;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] quotient_d;
    logic [WIDTH-1:0] remainder_d;

    // Absolute values of the incoming operands when signed, raw values otherwise
    always_comb begin
        dvd_mag = i_dividend;
        dsr_mag = i_divisor;
        if (i_signed && i_dividend[WIDTH-1]) dvd_mag = -i_dividend;
        if (i_signed && i_divisor[WIDTH-1])  dsr_mag = -i_divisor;
    end

    // Shift, trial-subtract with one extra bit, then keep the difference or restore
    always_comb begin
        shifted_rem = {rem_q, quo_q[WIDTH-1]};
        trial       = shifted_rem - {1'b0, dsr_q};
        step_ok     = ~trial[WIDTH];
        rem_d       = step_ok ? trial[WIDTH-1:0] : shifted_rem[WIDTH-1:0];
        quo_d       = {quo_q[WIDTH-2:0], step_ok};

        // Truncation toward zero: the quotient is negative when the signs differ,
        // and the remainder takes the dividend's sign. A zero divisor makes every
        // trial succeed, so the remainder ends up as the dividend magnitude, and
        // the sign fix-up turns it back into the original dividend.
        quotient_d  = quo_d;
        remainder_d = rem_d;
        if (signed_q && (dvd_sign_q ^ dsr_sign_q)) quotient_d  = -quo_d;
        if (signed_q && dvd_sign_q)                remainder_d = -rem_d;
        if (dbz_q)                                 quotient_d  = '1;
    end

    // Control FSM, iteration datapath and registered outputs
    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments, so every
        // right-hand side sees the pre-edge value, whatever the statement order.
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            signed_q      <= 1'b0;
            dvd_sign_q    <= 1'b0;
            dsr_sign_q    <= 1'b0;
            dbz_q         <= 1'b0;
            rem_q         <= '0;
            quo_q         <= '0;
            dsr_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (i_flush) begin
                // Abort: the result registers keep the last completed division
                state_q <= IDLE;
                busy_q  <= 1'b0;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE, DONE: begin
                        if (i_start) begin
                            state_q    <= BUSY;
                            busy_q     <= 1'b1;
                            cnt_q      <= CW'(WIDTH);
                            signed_q   <= i_signed;
                            dvd_sign_q <= i_dividend[WIDTH-1];
                            dsr_sign_q <= i_divisor[WIDTH-1];
                            dbz_q      <= (i_divisor == '0);
                            rem_q      <= '0;
                            quo_q      <= dvd_mag;
                            dsr_q      <= dsr_mag;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    BUSY: begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CW'(1)) begin
                            state_q       <= DONE;
                            busy_q        <= 1'b0;
                            done_q        <= 1'b1;
                            quotient_q    <= quotient_d;
                            remainder_q   <= remainder_d;
                            div_by_zero_q <= dbz_q;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_quotient    = quotient_q;
    assign o_remainder   = remainder_q;
    assign o_div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Directed testbench for iterative_divider (WIDTH = 32).
// A table of DIV/DIVU vectors is checked for results and latency. Hand-written
// sequences cover ignored starts, back-to-back starts, flush and reset.
module tb_iterative_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         i_start;
    logic         i_signed;
    logic         i_flush;
    logic [W-1:0] i_dividend;
    logic [W-1:0] i_divisor;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_quotient;
    logic [W-1:0] o_remainder;
    logic         o_div_by_zero;

    int n_checks = 0;
    int n_pass   = 0;

    iterative_divider #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_start      (i_start),
        .i_signed     (i_signed),
        .i_flush      (i_flush),
        .i_dividend   (i_dividend),
        .i_divisor    (i_divisor),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_quotient   (o_quotient),
        .o_remainder  (o_remainder),
        .o_div_by_zero(o_div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic         s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Called just after a falling edge; the start is sampled on the next rising edge (E0)
    task automatic start_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        i_start    = 1'b1;
        i_signed   = s;
        i_dividend = a;
        i_divisor  = b;
        @(negedge clk);
        i_start    = 1'b0;
        i_signed   = ~s;
        i_dividend = 32'hA5A5_A5A5;
        i_divisor  = 32'h0000_0000;
    endtask

    // Counts the edges after E0 until o_done is seen, with a bounded wait
    task automatic wait_done(output int lat, output int busy);
        lat  = 0;
        busy = 0;
        while (o_done !== 1'b1 && lat < 100) begin
            if (o_busy === 1'b1) busy++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int busy;
        int dcnt;

        vecs[0] = '{"u_100_7",      1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
        vecs[1] = '{"s_m7_2",       1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
        vecs[2] = '{"u_m7_2",       1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 32'h0000_0001, 1'b0};
        vecs[3] = '{"s_ovf",        1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0};
        vecs[4] = '{"u_max_max",    1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
        vecs[5] = '{"s_dbz",        1'b1, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1};
        vecs[6] = '{"u_dbz",        1'b0, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1};
        vecs[7] = '{"s_7_m2",       1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0};
        vecs[8] = '{"s_m8_m3",      1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'h0000_0002, 32'hFFFF_FFFE, 1'b0};
        vecs[9] = '{"s_dbz_neg",    1'b1, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b1};

        reset      = 1'b1;
        i_start    = 1'b0;
        i_signed   = 1'b0;
        i_flush    = 1'b0;
        i_dividend = '0;
        i_divisor  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_q",    o_quotient,  32'd0);
        check("rst_r",    o_remainder, 32'd0);
        check("rst_dbz",  32'(o_div_by_zero), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Table-driven results and latency
        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].s, vecs[i].a, vecs[i].b);
            wait_done(lat, busy);
            check({vecs[i].name, "_lat"},  32'(lat),  32'd32);
            check({vecs[i].name, "_busy"}, 32'(busy), 32'd32);
            check({vecs[i].name, "_q"},    o_quotient,  vecs[i].q);
            check({vecs[i].name, "_r"},    o_remainder, vecs[i].r);
            check({vecs[i].name, "_dbz"},  32'(o_div_by_zero), 32'(vecs[i].z));
            @(negedge clk);
            check({vecs[i].name, "_pulse"}, 32'(o_done), 32'd0);
            check({vecs[i].name, "_idle"},  32'(o_busy), 32'd0);
        end

        // Start pulsed while BUSY is ignored
        start_op(1'b0, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        i_start    = 1'b1;
        i_dividend = 32'd20;
        i_divisor  = 32'd3;
        @(negedge clk);
        i_start = 1'b0;
        wait_done(lat, busy);
        check("ign_lat", 32'(lat + 6), 32'd32);
        check("ign_q",   o_quotient,  32'd14);
        check("ign_r",   o_remainder, 32'd2);
        @(negedge clk);
        check("ign_noqueue", 32'(o_busy), 32'd0);

        // Back-to-back: new start in the DONE cycle
        start_op(1'b0, 32'd100, 32'd7);
        wait_done(lat, busy);
        check("b2b_first_q", o_quotient, 32'd14);
        start_op(1'b0, 32'd20, 32'd3);
        check("b2b_busy",   32'(o_busy), 32'd1);
        check("b2b_hold_r", o_remainder, 32'd2);
        wait_done(lat, busy);
        check("b2b_lat", 32'(lat), 32'd32);
        check("b2b_q",   o_quotient,  32'd6);
        check("b2b_r",   o_remainder, 32'd2);
        @(negedge clk);

        // Flush at cycle 10 of BUSY: no done, outputs keep 6 / 2
        start_op(1'b0, 32'h1234_5678, 32'd3);
        repeat (9) @(negedge clk);
        check("fl_hold_q", o_quotient, 32'd6);
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        check("fl_busy", 32'(o_busy), 32'd0);
        dcnt = 0;
        repeat (40) begin
            if (o_done === 1'b1) dcnt++;
            @(negedge clk);
        end
        check("fl_nodone", 32'(dcnt), 32'd0);
        check("fl_q", o_quotient,  32'd6);
        check("fl_r", o_remainder, 32'd2);
        start_op(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, busy);
        check("fl_next_lat", 32'(lat), 32'd32);
        check("fl_next_q",   o_quotient,  32'hFFFF_FFFD);
        check("fl_next_r",   o_remainder, 32'hFFFF_FFFF);
        @(negedge clk);

        // Flush wins over a simultaneous start
        i_flush = 1'b1;
        start_op(1'b0, 32'd100, 32'd7);
        i_flush = 1'b0;
        check("flst_busy", 32'(o_busy), 32'd0);
        dcnt = 0;
        repeat (40) begin
            if (o_done === 1'b1) dcnt++;
            @(negedge clk);
        end
        check("flst_nodone", 32'(dcnt), 32'd0);

        // Reset mid-BUSY zeroes every output, including a set div-by-zero flag
        start_op(1'b1, 32'h1234_5678, 32'd0);
        wait_done(lat, busy);
        check("pre_rst_dbz", 32'(o_div_by_zero), 32'd1);
        @(negedge clk);
        start_op(1'b0, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mrst_busy", 32'(o_busy), 32'd0);
        check("mrst_done", 32'(o_done), 32'd0);
        check("mrst_q",    o_quotient,  32'd0);
        check("mrst_r",    o_remainder, 32'd0);
        check("mrst_dbz",  32'(o_div_by_zero), 32'd0);
        dcnt = 0;
        repeat (40) begin
            if (o_done === 1'b1) dcnt++;
            @(negedge clk);
        end
        check("mrst_nodone", 32'(dcnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
